// File: rtl/histogram_accumulator_pkg.sv
// Shared types for the histogram engine: FSM state encoding and the pipeline drain length.
package histogram_accumulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_FLUSH,
    ST_READOUT
  } state_e;

  // Cycles spent after the last pixel so the final read-modify-write has committed.
  localparam int unsigned FLUSH_CYCLES = 2;

endpackage

// File: rtl/RAM_Generator.sv
// Dual-port RAM, one write port and one synchronous read port.
// A read and a write to the same address on the same edge return the old data.
module RAM_Generator #(
  parameter int C_DATA_WIDTH = 16,
  parameter int C_DEPTH      = 256,
  parameter int C_CE_IN      = 0,
  parameter int C_ADDR_WIDTH = $clog2(C_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    ce_i,
  input  logic                    wr_en_i,
  input  logic [C_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [C_DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [C_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [C_DATA_WIDTH-1:0] rd_data_o
);

  logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] rd_data_q;
  logic                    en;

  assign en = (C_CE_IN != 0) ? ce_i : 1'b1;

  always_ff @(posedge clk_i) begin
    if (en && wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (en && rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/histogram_accumulator.sv
// Frame histogram: clears the bin RAM, counts pixels by read-modify-write, then streams bins out.
// Pixels accepted only in ACCUM; readout holds its outputs while rd_ready_i is low.
module histogram_accumulator
  import histogram_accumulator_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic                     pixel_valid_i,
  input  logic [C_PIXEL_WIDTH-1:0] pixel_data_i,
  input  logic                     pixel_last_i,
  output logic                     pixel_ready_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [C_PIXEL_WIDTH-1:0] rd_bin_o,
  output logic [C_COUNT_WIDTH-1:0] rd_count_o,
  output logic                     rd_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int N = 1 << C_PIXEL_WIDTH;
  localparam logic [C_PIXEL_WIDTH-1:0] LAST_BIN   = '1;
  localparam logic [C_PIXEL_WIDTH-1:0] BIN_ONE    = {{(C_PIXEL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_PIXEL_WIDTH-1:0] FLUSH_LAST = C_PIXEL_WIDTH'(FLUSH_CYCLES - 1);
  localparam logic [C_COUNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE    = {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q;
  logic [C_PIXEL_WIDTH-1:0] cnt_q;
  logic                     pixel_ready_q, busy_q, done_q, rd_valid_q, rd_last_q;
  logic [C_PIXEL_WIDTH-1:0] rd_bin_q, rd_bin_d;
  logic                     s1_vld_q, fwd_vld_q;
  logic [C_PIXEL_WIDTH-1:0] s1_bin_q, fwd_bin_q;
  logic [C_COUNT_WIDTH-1:0] fwd_val_q;

  logic                     accept, rd_hs;
  logic [C_COUNT_WIDTH-1:0] ram_rd_dat, s1_old, s1_new, ram_wr_dat;
  logic                     ram_wr_en, ram_rd_en;
  logic [C_PIXEL_WIDTH-1:0] ram_wr_addr, ram_rd_addr;

  assign accept = pixel_valid_i & pixel_ready_q;
  assign rd_hs  = rd_valid_q & rd_ready_i;

  // The RAM hands back pre-write data when S0 reads the bin S1 is writing; take it from the forward register.
  assign s1_old = (fwd_vld_q && fwd_bin_q == s1_bin_q) ? fwd_val_q : ram_rd_dat;
  assign s1_new = (s1_old == CNT_MAX) ? s1_old : s1_old + CNT_ONE;

  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = s1_bin_q;
    ram_wr_dat  = s1_new;
    if (state_q == ST_CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = cnt_q;
      ram_wr_dat  = '0;
    end else if (s1_vld_q) begin
      ram_wr_en = 1'b1;
    end
  end

  // Readout re-reads the current bin while stalled so the RAM output register stays put.
  always_comb begin
    rd_bin_d = rd_bin_q;
    if (!rd_valid_q) rd_bin_d = '0;
    else if (rd_hs && !rd_last_q) rd_bin_d = rd_bin_q + BIN_ONE;
    ram_rd_en   = accept;
    ram_rd_addr = pixel_data_i;
    if (state_q == ST_READOUT) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = rd_bin_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pixel_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_bin_q      <= '0;
      s1_vld_q      <= 1'b0;
      s1_bin_q      <= '0;
      fwd_vld_q     <= 1'b0;
      fwd_bin_q     <= '0;
      fwd_val_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      s1_vld_q  <= accept;
      s1_bin_q  <= pixel_data_i;
      fwd_vld_q <= s1_vld_q;
      fwd_bin_q <= s1_bin_q;
      fwd_val_q <= s1_new;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + BIN_ONE;
          if (cnt_q == LAST_BIN) begin
            state_q       <= ST_ACCUM;
            pixel_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept && pixel_last_i) begin
            state_q       <= ST_FLUSH;
            pixel_ready_q <= 1'b0;
            cnt_q         <= '0;
          end
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q + BIN_ONE;
          if (cnt_q == FLUSH_LAST) state_q <= ST_READOUT;
        end
        ST_READOUT: begin
          if (rd_hs && rd_last_q) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_bin_q   <= '0;
          end else begin
            rd_valid_q <= 1'b1;
            rd_bin_q   <= rd_bin_d;
            rd_last_q  <= (rd_bin_d == LAST_BIN);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  RAM_Generator #(
    .C_DATA_WIDTH(C_COUNT_WIDTH),
    .C_DEPTH     (N),
    .C_CE_IN     (0)
  ) u_ram (
    .clk_i    (clk_i),
    .ce_i     (1'b1),
    .wr_en_i  (ram_wr_en),
    .wr_addr_i(ram_wr_addr),
    .wr_data_i(ram_wr_dat),
    .rd_en_i  (ram_rd_en),
    .rd_addr_i(ram_rd_addr),
    .rd_data_o(ram_rd_dat)
  );

  assign pixel_ready_o = pixel_ready_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_bin_o      = rd_bin_q;
  assign rd_count_o    = rd_valid_q ? ram_rd_dat : '0;
  assign rd_last_o     = rd_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator with 16 bins of 4-bit saturating counters.
module tb_histogram_accumulator;

  logic       clk = 1'b0;
  logic       rstn_i, start_i, pixel_valid_i, pixel_last_i, rd_ready_i;
  logic [3:0] pixel_data_i;
  logic       pixel_ready_o, rd_valid_o, rd_last_o, busy_o, done_o;
  logic [3:0] rd_bin_o, rd_count_o;

  histogram_accumulator #(.C_PIXEL_WIDTH(4), .C_COUNT_WIDTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
    .pixel_valid_i(pixel_valid_i), .pixel_data_i(pixel_data_i), .pixel_last_i(pixel_last_i),
    .pixel_ready_o(pixel_ready_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_bin_o(rd_bin_o), .rd_count_o(rd_count_o), .rd_last_o(rd_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hist[16];
  int got_hist[16];
  int exp_bin = 0;
  bit last_hs = 1'b0;
  bit cmp_en = 1'b0;
  bit prev_stall = 1'b0;
  int prev_bin, prev_cnt;
  int frame_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected readout: bins in ascending order, each count = min(pixels of that bin, 15).
  task automatic compare_outputs();
    if (!cmp_en) return;
    check("done_pulse", int'(done_o), int'(last_hs));
    if (done_o) check("busy_at_done", int'(busy_o), 0);
    last_hs = 1'b0;
    if (prev_stall) begin
      check("stall_hold_valid", int'(rd_valid_o), 1);
      check("stall_hold_bin", int'(rd_bin_o), prev_bin);
      check("stall_hold_count", int'(rd_count_o), prev_cnt);
    end
    if (rd_valid_o) begin
      if (exp_bin > 15) begin
        check("extra_result", exp_bin, 15);
      end else begin
        check("rd_bin", int'(rd_bin_o), exp_bin);
        check("rd_count", int'(rd_count_o), exp_hist[exp_bin]);
        check("rd_last", int'(rd_last_o), int'(exp_bin == 15));
      end
      if (rd_ready_i) begin
        got_hist[rd_bin_o] = int'(rd_count_o);
        if (exp_bin == 15) last_hs = 1'b1;
        exp_bin++;
      end
    end else begin
      check("rd_last_idle", int'(rd_last_o), 0);
    end
    prev_stall = rd_valid_o && !rd_ready_i;
    prev_bin   = int'(rd_bin_o);
    prev_cnt   = int'(rd_count_o);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic start_and_clear();
    int n;
    foreach (exp_hist[i]) begin
      exp_hist[i] = 0;
      got_hist[i] = -1;
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", int'(busy_o), 1);
    n = 0;
    while (!pixel_ready_o && n < 64) begin
      pixel_valid_i = 1'($urandom_range(0, 1));
      pixel_data_i  = 4'($urandom_range(0, 15));
      start_i       = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pixel_valid_i = 1'b0;
    start_i       = 1'b0;
    check("clear_cycles", n, 16);
  endtask

  task automatic send_pixels(input bit with_last);
    for (int i = 0; i < frame_q.size(); i++) begin
      pixel_valid_i = (frame_q[i] >= 0);
      pixel_data_i  = (frame_q[i] >= 0) ? 4'(frame_q[i]) : 4'($urandom_range(0, 15));
      pixel_last_i  = with_last && (i == frame_q.size() - 1);
      start_i       = 1'($urandom_range(0, 1));
      if (frame_q[i] >= 0) begin
        check("pixel_ready", int'(pixel_ready_o), 1);
        if (exp_hist[frame_q[i]] < 15) exp_hist[frame_q[i]]++;
      end
      tick();
    end
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
    start_i       = 1'b0;
  endtask

  task automatic readout(input bit rnd_rdy, input bit chk_tput);
    int n;
    check("ready_drop_after_last", int'(pixel_ready_o), 0);
    check("busy_in_flush", int'(busy_o), 1);
    n = 0;
    rd_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!rd_valid_o && n < 32) begin
      tick();
      n++;
      rd_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("first_valid_latency", n, 3);
    n = 0;
    while (!done_o && n < 400) begin
      rd_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i    = rd_valid_o ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    start_i    = 1'b0;
    rd_ready_i = 1'b0;
    check("done_seen", int'(done_o), 1);
    if (chk_tput) check("readout_cycles", n, 16);
    check("bins_delivered", exp_bin, 16);
    exp_bin = 0;
  endtask

  task automatic run_frame(input bit rnd_rdy, input bit chk_tput);
    start_and_clear();
    send_pixels(1'b1);
    readout(rnd_rdy, chk_tput);
  endtask

  initial begin
    int len;
    rstn_i = 1'b0; start_i = 1'b0; pixel_valid_i = 1'b0; pixel_last_i = 1'b0;
    pixel_data_i = '0; rd_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_ready", int'(pixel_ready_o), 0);
    check("rst_rd_valid", int'(rd_valid_o), 0);
    check("rst_rd_last", int'(rd_last_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_rd_bin", int'(rd_bin_o), 0);
    check("rst_rd_count", int'(rd_count_o), 0);
    rstn_i = 1'b1;
    tick();
    check("idle_busy", int'(busy_o), 0);
    cmp_en = 1'b1;

    frame_q = '{3, 3, 3, 5};
    run_frame(1'b0, 1'b1);
    check("f1_bin3", got_hist[3], 3);
    check("f1_bin5", got_hist[5], 1);
    check("f1_bin0", got_hist[0], 0);
    check("f1_bin15", got_hist[15], 0);

    frame_q = '{7, 7, -1, 7, -1, -1, 7, 9, 7};
    run_frame(1'b0, 1'b1);
    check("f2_bin7", got_hist[7], 5);
    check("f2_bin9", got_hist[9], 1);
    check("f2_bin8", got_hist[8], 0);

    frame_q.delete();
    repeat (20) frame_q.push_back(2);
    run_frame(1'b1, 1'b0);
    check("f3_bin2_saturated", got_hist[2], 15);

    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(20, 60));
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        if (i != len - 1 && $urandom_range(0, 3) == 0) frame_q.push_back(-1);
        else if ($urandom_range(0, 1) == 1) frame_q.push_back(int'($urandom_range(0, 2)));
        else frame_q.push_back(int'($urandom_range(0, 15)));
      end
      run_frame(1'b1, 1'b0);
    end

    start_and_clear();
    frame_q = '{1, 1, 1, 1, 1};
    send_pixels(1'b0);
    rstn_i = 1'b0;
    cmp_en = 1'b0;
    tick();
    check("midrst_pixel_ready", int'(pixel_ready_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_rd_valid", int'(rd_valid_o), 0);
    rstn_i = 1'b1;
    exp_bin = 0; last_hs = 1'b0; prev_stall = 1'b0;
    tick();
    cmp_en = 1'b1;
    frame_q = '{1};
    run_frame(1'b1, 1'b0);
    check("after_reset_bin1", got_hist[1], 1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/histogram_accumulator.md
# histogram_accumulator

Frame-level histogram engine. Counts 2^C_PIXEL_WIDTH intensity bins from a pixel stream by read-modify-write on an internal dual-port synchronous-read RAM, then streams the finished bin counts out over a valid/ready interface. It sits between the pixel source and the downstream histogram consumer (equalisation LUT builder). It owns the clear, accumulate and readout phases of the histogram memory.

## Interface
- C_PIXEL_WIDTH, 8, pixel/bin-index width; bin count N = 2^C_PIXEL_WIDTH
- C_COUNT_WIDTH, 16, bin counter width; counters saturate at 2^C_COUNT_WIDTH-1
- clk_i  in  1  single clock, all logic on posedge
- rstn_i  in  1  reset, synchronous, active-low
- start_i  in  1  single-cycle request to begin a frame; honoured only in IDLE
- pixel_valid_i  in  1  pixel_data_i valid
- pixel_data_i  in  C_PIXEL_WIDTH  pixel value = bin index
- pixel_last_i  in  1  marks last pixel of frame (qualified by accept)
- pixel_ready_o  out  1  high only in ACCUM; accept = pixel_valid_i & pixel_ready_o
- rd_valid_o  out  1  bin result valid
- rd_ready_i  in  1  consumer ready; handshake = rd_valid_o & rd_ready_i
- rd_bin_o  out  C_PIXEL_WIDTH  bin index of current result
- rd_count_o  out  C_COUNT_WIDTH  count of rd_bin_o
- rd_last_o  out  1  high with bin N-1
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on return to IDLE after readout

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, READOUT.
- IDLE: start_i -> CLEAR. Other inputs ignored.
- CLEAR: write 0 to addresses 0..N-1, one per cycle, exactly N cycles -> ACCUM.
- ACCUM: pixel_ready_o=1. Accepted pixel issues RAM read of its bin (stage S0). Next cycle (S1): new = old+1, held at max if old = all-ones; written back at end of S1. Accepted pixel with pixel_last_i -> FLUSH.
- Hazard: RAM returns pre-write data when read and write hit the same edge. S1 data is taken from a one-entry forward register (last written bin/value) when its bin equals the bin written on the previous cycle; else from RAM. Only distance-1 forwarding is needed; distance ≥2 reads see committed data.
- FLUSH: 2 cycles, drains S1 and forward register -> READOUT.
- READOUT: bins 0..N-1 in ascending order, one per handshake. rd_bin_o/rd_count_o/rd_last_o stable while rd_valid_o & !rd_ready_i. RAM read address is advanced combinationally on handshake so throughput is 1 bin/cycle with rd_ready_i held high. Handshake on bin N-1 -> IDLE with done_o pulse.
- start_i outside IDLE ignored; pixel_valid_i outside ACCUM ignored (not accepted).
- Reset (any state, including mid-CLEAR/ACCUM/READOUT): next cycle IDLE; all outputs 0; pipeline and forward register invalidated. RAM contents undefined; next frame's CLEAR restores zeros.

## Timing
- start_i sampled at edge 0 -> CLEAR cycles 1..N; pixel_ready_o high from cycle N+1.
- Accept-to-commit latency: 2 edges (read edge, write edge).
- pixel_last_i accepted at cycle t -> FLUSH t+1, t+2; READOUT entered t+3; rd_valid_o first high t+4 (one priming cycle).
- done_o high the cycle after final handshake; busy_o low that same cycle.
- Output reset values: pixel_ready_o, rd_valid_o, rd_last_o, busy_o, done_o = 0; rd_bin_o, rd_count_o = 0.

## Structure
- Shared package: state encoding enum (IDLE, CLEAR, ACCUM, FLUSH, READOUT), FLUSH length constant.
- One sub-module: instantiate the team's existing dual-port synchronous-read RAM (RAM_Generator) with C_DATA_WIDTH=C_COUNT_WIDTH, C_DEPTH=N, C_CE_IN=0. Write port shared by CLEAR and S1 via mux; read port shared by S0 and READOUT.

## Test plan
- W=4, C=8: start, 16 clear cycles, pixels 3,3,3,5 back-to-back (last on 5), rd_ready_i=1 -> bin3=3, bin5=1, all others 0, 16 results in consecutive cycles, rd_last_o on bin 15.
- Hazard mix: 7,7,gap,7,gap,gap,7,9,7 -> bin7=5, bin9=1 (covers distance 1, 2, 3).
- Saturation, C=4: 20 consecutive pixels of bin 2 -> bin2=15, no wrap to 0.
- Backpressure: random rd_ready_i during READOUT -> each bin exactly once in order, outputs stable while stalled, done_o one cycle after bin-15 handshake.
- Reset mid-ACCUM after 5 pixels of bin 1, then new frame with one pixel of bin 1 -> bin1=1.
- start_i asserted during ACCUM and READOUT, pixel_valid_i during CLEAR -> no state change, no counts affected.
